multicycle_adder_nbit: RTL
==========================

Name: multicycle_adder_nbit

Overview:
- Parametrised, multi-cycle N-bit adder that adds CHUNK_BITS per clock, LSB chunk first.
- Uses a start/busy/done handshake.
- Successor to the fixed-width combinational adders. Trades latency for a short carry chain at wide widths.
- Adds selectable signed or unsigned overflow detection.
- Sits in the datapath as an arithmetic unit driven by a controller FSM.

Parameters:
- NUM_BITS, 16, operand/sum width; must be a multiple of CHUNK_BITS and >= 2.
- CHUNK_BITS, 4, bits added per clock; 1 <= CHUNK_BITS <= NUM_BITS.
- NUM_CHUNKS (localparam), NUM_BITS/CHUNK_BITS, number of ADD cycles.

Ports:
- clk  input  1  system clock, rising-edge.
- n_rst  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled on the rising edge; accepted only in IDLE or DONE.
- a  input  NUM_BITS  operand A; latched on the accepting edge.
- b  input  NUM_BITS  operand B; latched on the accepting edge.
- carry_in  input  1  carry into bit 0; latched on the accepting edge.
- signed_mode  input  1  0 = unsigned overflow, 1 = two's-complement overflow; latched on the accepting edge.
- busy  output  1  high while in ADD.
- done  output  1  one-cycle pulse; sum/overflow valid from this cycle.
- sum  output  NUM_BITS  registered result; holds until the next result is published.
- overflow  output  1  registered overflow flag; updates together with sum.

Behaviour:
- Reset: one clock (clk); asynchronous, active-low reset (n_rst). On n_rst=0, immediately: state=IDLE, busy=0, done=0, sum=0, overflow=0, chunk index=0, internal operand/accumulator registers=0. Reset mid-operation aborts the operation with no result published.
- States: IDLE, ADD, DONE, held in a typedef enum.
- IDLE: start=1 latches a, b, carry_in, signed_mode; clears accumulator and index; sets the running carry to carry_in; goes to ADD. start=0 stays in IDLE.
- ADD: each edge adds chunk [idx*CHUNK_BITS +: CHUNK_BITS] of A and B plus the running carry.
  - Writes the chunk into the accumulator, updates the running carry, idx++.
  - On the edge processing idx=NUM_CHUNKS-1: capture sum<=accumulator (including the final chunk) and overflow, then go to DONE.
- Overflow rule: unsigned mode = carry out of bit NUM_BITS-1. Signed mode = carry into bit NUM_BITS-1 XOR carry out of bit NUM_BITS-1.
- DONE: done=1 for exactly one cycle. start=1 here behaves exactly as start in IDLE (back-to-back accepted, goes to ADD); otherwise go to IDLE.
- busy=1 exactly in ADD. busy and done are never both high.
- Latency: start accepted at edge E -> done high in the cycle following edge E+NUM_CHUNKS. Throughput: one result per NUM_CHUNKS+1 cycles.
- Outputs: busy and done are decoded from state; no combinational path from inputs to outputs.
- Busy handling: start during ADD is ignored. Operand changes during ADD are ignored.
- Outputs hold: sum/overflow retain the last result through IDLE and the following ADD until the next publication.
- Width rule: the internal chunk adder is CHUNK_BITS+1 wide. The MSB carry-in is taken from the final chunk's internal carry at bit CHUNK_BITS-1.
- Degenerate case CHUNK_BITS=NUM_BITS: NUM_CHUNKS=1; done appears 2 cycles after the start edge.

Decomposition:
- Package adder_pkg: state enum (IDLE, ADD, DONE) and a function computing NUM_CHUNKS with an elaboration-time check that NUM_BITS % CHUNK_BITS == 0.
- Sub-module adder_chunk (parametrised CHUNK_BITS, combinational):
  - Inputs: a_chunk, b_chunk, cin.
  - Outputs: s_chunk, cout, msb_cin (carry into the chunk MSB, used for signed overflow).
- Top module: FSM, index counter, operand/accumulator registers, output registers.

Test Plan (NUM_BITS=16, CHUNK_BITS=4 unless stated):
- Reset: start a=0x1234 b=0x1111; pull n_rst low 2 cycles later -> busy=0, done=0, sum=0x0000, overflow=0 immediately (asynchronously); no done pulse afterwards.
- Unsigned wrap and latency: a=0xFFFF b=0x0001 cin=0 signed_mode=0 -> done exactly 4 edges after the start edge (cycle following edge E+4), sum=0x0000, overflow=1; busy high for exactly 4 cycles.
- Signed overflow:
  - a=0x7FFF b=0x0001 signed_mode=1 -> sum=0x8000, overflow=1.
  - a=0xFFFF b=0x0001 signed_mode=1 -> sum=0x0000, overflow=0.
- Cross-chunk carry: a=0x00FF b=0x0000 cin=1 -> sum=0x0100, overflow=0 (carry propagates through chunks 0-1 into chunk 2).
- Handshake:
  - start with a=0x0003 b=0x0004, then start with a=0xAAAA mid-ADD -> single done, sum=0x0007.
  - start held high in the DONE cycle with a=0x0010 b=0x0020 -> second done 5 cycles later, sum=0x0030.
- Exhaustive: NUM_BITS=8, CHUNK_BITS=2, all a, b, carry_in in both modes -> sum and overflow match the reference model {carry_out, sum}=a+b+carry_in, with signed overflow (a[7]==b[7])&&(sum[7]!=a[7]).

Source files
------------

// File: rtl/adder_pkg.sv
// Shared types and elaboration helpers for the multi-cycle chunked adder.
package adder_pkg;

  // Controller states: waiting, adding one chunk per clock, publishing result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of ADD cycles for a given width split. Returns 0 when the width is
  // not an exact multiple of the chunk size so the top can refuse to elaborate.
  function automatic int calc_num_chunks(input int num_bits, input int chunk_bits);
    if (chunk_bits < 1 || chunk_bits > num_bits || (num_bits % chunk_bits) != 0)
      return 0;
    return num_bits / chunk_bits;
  endfunction

endpackage

// File: rtl/multicycle_adder_nbit_if.sv
// Start/busy/done handshake and operand/result bus of the multi-cycle adder.
interface multicycle_adder_nbit_if #(
  parameter int NUM_BITS = 16
);
  logic                start;
  logic [NUM_BITS-1:0] a;
  logic [NUM_BITS-1:0] b;
  logic                carry_in;
  logic                signed_mode;
  logic                busy;
  logic                done;
  logic [NUM_BITS-1:0] sum;
  logic                overflow;

  // Controller side: issues requests and consumes results.
  modport master (
    output start, a, b, carry_in, signed_mode,
    input  busy, done, sum, overflow
  );

  // Adder side.
  modport slave (
    input  start, a, b, carry_in, signed_mode,
    output busy, done, sum, overflow
  );
endinterface

// File: rtl/adder_chunk.sv
// Combinational CHUNK_BITS-wide adder slice. Also exposes the carry into its
// MSB so the top can form two's-complement overflow on the final chunk.
module adder_chunk #(
  parameter int CHUNK_BITS = 4
) (
  input  logic [CHUNK_BITS-1:0] a_chunk,
  input  logic [CHUNK_BITS-1:0] b_chunk,
  input  logic                  cin,
  output logic [CHUNK_BITS-1:0] s_chunk,
  output logic                  cout,
  output logic                  msb_cin
);

  // One bit wider than the chunk so the carry out falls into the top bit.
  logic [CHUNK_BITS:0] total;

  assign total   = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK_BITS{1'b0}}, cin};
  assign s_chunk = total[CHUNK_BITS-1:0];
  assign cout    = total[CHUNK_BITS];
  // Sum bit = a ^ b ^ carry_in at that bit, so the carry in is recovered by XOR.
  assign msb_cin = a_chunk[CHUNK_BITS-1] ^ b_chunk[CHUNK_BITS-1] ^ total[CHUNK_BITS-1];

endmodule

// File: rtl/multicycle_adder_nbit.sv
// Multi-cycle N-bit adder: adds CHUNK_BITS per clock, LSB chunk first, with
// selectable unsigned/signed overflow and a start/busy/done handshake.
module multicycle_adder_nbit
  import adder_pkg::*;
#(
  parameter int NUM_BITS   = 16,
  parameter int CHUNK_BITS = 4
) (
  input  logic                   clk,
  input  logic                   n_rst,
  multicycle_adder_nbit_if.slave bus
);

  localparam int NUM_CHUNKS = calc_num_chunks(NUM_BITS, CHUNK_BITS);
  localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

  // Refuse to elaborate an unusable width split.
  generate
    if (NUM_CHUNKS < 1 || NUM_BITS < 2) begin : g_param_check
      $error("multicycle_adder_nbit: NUM_BITS must be >= 2 and a multiple of CHUNK_BITS");
    end
  endgenerate

  state_t              state_reg, state_next;
  logic [IDX_W-1:0]    idx_reg;
  logic [NUM_BITS-1:0] a_reg, b_reg;
  logic [NUM_BITS-1:0] acc_reg, acc_next;
  logic [NUM_BITS-1:0] sum_reg;
  logic                carry_reg;
  logic                signed_reg;
  logic                overflow_reg;

  logic                  accept;
  logic                  last_chunk;
  logic [NUM_CHUNKS-1:0] chunk_sel;
  logic [CHUNK_BITS-1:0] a_chunk, b_chunk, s_chunk;
  logic                  chunk_cout, chunk_msb_cin;

  // A request is only taken when not already adding.
  assign accept     = bus.start && ((state_reg == IDLE) || (state_reg == DONE));
  assign last_chunk = (idx_reg == LAST_IDX);

  // One-hot decode of the chunk currently being processed.
  generate
    for (genvar gi = 0; gi < NUM_CHUNKS; gi++) begin : g_chunk_sel
      assign chunk_sel[gi] = (idx_reg == IDX_W'(gi));
    end
  endgenerate

  // Select the active operand chunks and merge the chunk result into the accumulator.
  always_comb begin
    a_chunk  = '0;
    b_chunk  = '0;
    acc_next = acc_reg;
    for (int i = 0; i < NUM_CHUNKS; i++) begin
      if (chunk_sel[i]) begin
        a_chunk = a_reg[i*CHUNK_BITS +: CHUNK_BITS];
        b_chunk = b_reg[i*CHUNK_BITS +: CHUNK_BITS];
        acc_next[i*CHUNK_BITS +: CHUNK_BITS] = s_chunk;
      end
    end
  end

  adder_chunk #(
    .CHUNK_BITS(CHUNK_BITS)
  ) u_chunk (
    .a_chunk (a_chunk),
    .b_chunk (b_chunk),
    .cin     (carry_reg),
    .s_chunk (s_chunk),
    .cout    (chunk_cout),
    .msb_cin (chunk_msb_cin)
  );

  // State register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic: DONE lasts one cycle and may chain straight into ADD.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.start) state_next = ADD;
      ADD:     if (last_chunk) state_next = DONE;
      DONE:    state_next = bus.start ? ADD : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand capture, chunk-serial accumulation and result publication.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      idx_reg      <= '0;
      a_reg        <= '0;
      b_reg        <= '0;
      acc_reg      <= '0;
      sum_reg      <= '0;
      carry_reg    <= 1'b0;
      signed_reg   <= 1'b0;
      overflow_reg <= 1'b0;
    end else if (accept) begin
      a_reg      <= bus.a;
      b_reg      <= bus.b;
      carry_reg  <= bus.carry_in;
      signed_reg <= bus.signed_mode;
      acc_reg    <= '0;
      idx_reg    <= '0;
    end else if (state_reg == ADD) begin
      acc_reg   <= acc_next;
      carry_reg <= chunk_cout;
      if (last_chunk) begin
        idx_reg      <= '0;
        sum_reg      <= acc_next;
        overflow_reg <= signed_reg ? (chunk_cout ^ chunk_msb_cin) : chunk_cout;
      end else begin
        idx_reg <= idx_reg + IDX_W'(1);
      end
    end
  end

  assign bus.busy     = (state_reg == ADD);
  assign bus.done     = (state_reg == DONE);
  assign bus.sum      = sum_reg;
  assign bus.overflow = overflow_reg;

endmodule
